// File: rtl/spi_cmd_sequencer_pkg.sv
// rtl/spi_cmd_sequencer_pkg.sv - opcodes, return bytes and FSM states for the SPI command sequencer
package spi_cmd_sequencer_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h03;

    localparam logic [7:0] IDLE_BYTE  = 8'h00;
    localparam logic [7:0] ERR_BYTE   = 8'hFF;

    typedef enum logic [2:0] {
        ST_CMD   = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_STAT  = 3'd4,
        ST_IGN   = 3'd5
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// rtl/spi_cmd_sequencer_if.sv - register bus between the sequencer and the cart register file
interface spi_cmd_sequencer_if #(
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re,
        output reg_rdata
    );
endinterface

// File: rtl/spi_cmd_sequencer_sync_edge_det.sv
// rtl/spi_cmd_sequencer_sync_edge_det.sv - multi-flop synchronizer with rise/fall pulses
module spi_cmd_sequencer_sync_edge_det #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            last_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~last_q;
    assign fall = ~q & last_q;
endmodule

// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - decodes CMD/ADDR/DATA SPI frames into register-bus strobes and MISO bytes
module spi_cmd_sequencer
    import spi_cmd_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_cs,
    input  logic                 spi_busy,
    input  logic [7:0]           spi_in_byte,
    output logic [7:0]           spi_out_byte,
    spi_cmd_sequencer_if.master  reg_bus,
    input  logic [7:0]           status,
    output logic                 frame_active,
    output logic [7:0]           err_cnt
);
    logic busy_fall, busy_level_unused, busy_rise_unused;
    logic cs_q, cs_rise, cs_fall_unused;

    spi_cmd_sequencer_sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_busy_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (spi_busy),
        .q    (busy_level_unused),
        .rise (busy_rise_unused),
        .fall (busy_fall)
    );

    spi_cmd_sequencer_sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (spi_cs),
        .q    (cs_q),
        .rise (cs_rise),
        .fall (cs_fall_unused)
    );

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        out_q, out_d;
    logic [7:0]        err_q, err_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              is_read_q, is_read_d;
    logic              rd_cap_q, rd_cap_d;
    logic              byte_done;

    // A byte finishing in the same cycle cs rises still belongs to the frame.
    assign byte_done = busy_fall & (~cs_q | cs_rise);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        out_d      = out_q;
        err_d      = err_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        is_read_d  = is_read_q;
        rd_cap_d   = re_q;

        // Read data arrives the cycle after the strobe and becomes the next MISO byte.
        if (rd_cap_q && !cs_q) begin
            out_d = reg_bus.reg_rdata;
        end

        if (byte_done) begin
            unique case (state_q)
                ST_CMD: begin
                    if (spi_in_byte == CMD_WRITE || spi_in_byte == CMD_READ) begin
                        state_d   = ST_ADDR;
                        is_read_d = (spi_in_byte == CMD_READ);
                        out_d     = IDLE_BYTE;
                    end else if (spi_in_byte == CMD_STATUS) begin
                        state_d = ST_STAT;
                        out_d   = status;
                    end else begin
                        state_d = ST_IGN;
                        out_d   = ERR_BYTE;
                        err_d   = sat_inc8(err_q);
                    end
                end
                ST_ADDR: begin
                    if (is_read_q) begin
                        state_d    = ST_RDATA;
                        re_d       = 1'b1;
                        reg_addr_d = spi_in_byte[ADDR_W-1:0];
                        addr_d     = spi_in_byte[ADDR_W-1:0] + 1'b1;
                    end else begin
                        state_d = ST_WDATA;
                        addr_d  = spi_in_byte[ADDR_W-1:0];
                        out_d   = IDLE_BYTE;
                    end
                end
                ST_WDATA: begin
                    we_d       = 1'b1;
                    reg_addr_d = addr_q;
                    wdata_d    = spi_in_byte;
                    addr_d     = addr_q + 1'b1;
                    out_d      = IDLE_BYTE;
                end
                ST_RDATA: begin
                    re_d       = 1'b1;
                    reg_addr_d = addr_q;
                    addr_d     = addr_q + 1'b1;
                end
                ST_STAT: out_d = status;
                ST_IGN:  out_d = ERR_BYTE;
                default: state_d = ST_CMD;
            endcase
        end

        if (cs_rise) begin
            state_d  = ST_CMD;
            out_d    = IDLE_BYTE;
            rd_cap_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CMD;
            addr_q     <= '0;
            reg_addr_q <= '0;
            wdata_q    <= 8'h00;
            out_q      <= IDLE_BYTE;
            err_q      <= 8'h00;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            is_read_q  <= 1'b0;
            rd_cap_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            reg_addr_q <= reg_addr_d;
            wdata_q    <= wdata_d;
            out_q      <= out_d;
            err_q      <= err_d;
            we_q       <= we_d;
            re_q       <= re_d;
            is_read_q  <= is_read_d;
            rd_cap_q   <= rd_cap_d;
        end
    end

    assign spi_out_byte      = out_q;
    assign reg_bus.reg_addr  = reg_addr_q;
    assign reg_bus.reg_wdata = wdata_q;
    assign reg_bus.reg_we    = we_q;
    assign reg_bus.reg_re    = re_q;
    assign frame_active      = ~cs_q;
    assign err_cnt           = err_q;
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - scoreboard bench with a byte-level SPI slave/master model and register file
module tb_spi_cmd_sequencer;
    localparam int HP = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_cs = 1'b1;
    logic       spi_busy = 1'b0;
    logic [7:0] spi_in_byte = 8'h00;
    logic [7:0] status = 8'h00;
    logic [7:0] spi_out_byte;
    logic       frame_active;
    logic [7:0] err_cnt;
    logic       miso_sample = 1'b0;

    spi_cmd_sequencer_if #(.ADDR_W(8)) bus ();

    spi_cmd_sequencer #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_cs       (spi_cs),
        .spi_busy     (spi_busy),
        .spi_in_byte  (spi_in_byte),
        .spi_out_byte (spi_out_byte),
        .reg_bus      (bus.master),
        .status       (status),
        .frame_active (frame_active),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    // Register file seen by the DUT
    logic [7:0] rf_mem [256];
    logic [7:0] rf_rdata = 8'h00;
    assign bus.reg_rdata = rf_rdata;
    always @(posedge clk) begin
        if (bus.reg_we) rf_mem[bus.reg_addr] = bus.reg_wdata;
        if (bus.reg_re) rf_rdata <= rf_mem[bus.reg_addr];
    end

    // Reference model state
    logic [7:0]  ref_mem [256];
    logic [7:0]  exp_miso [$];
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    int          err_model = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  fq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    always @(posedge miso_sample) begin
        if (exp_miso.size() == 0) flag("miso_unexpected");
        else check("miso", spi_out_byte, exp_miso.pop_front());
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.reg_we && bus.reg_re) flag("we_re_overlap");
            if (bus.reg_we) begin
                if (exp_wr.size() == 0) flag("write_unexpected");
                else check("write", {bus.reg_addr, bus.reg_wdata}, exp_wr.pop_front());
            end
            if (bus.reg_re) begin
                if (exp_rd.size() == 0) flag("read_unexpected");
                else check("read_addr", bus.reg_addr, exp_rd.pop_front());
            end
        end
    end

    // Expected results of one frame from its byte list; bytes at index >= ncomplete never finish.
    task automatic expect_frame(input int ncomplete, input logic [7:0] st);
        logic [7:0] cmd;
        logic [7:0] a;
        cmd = fq[0];
        for (int k = 0; k < fq.size(); k++) begin
            if (k == 0)             exp_miso.push_back(8'h00);
            else if (cmd == 8'h01)  exp_miso.push_back(8'h00);
            else if (cmd == 8'h02) begin
                a = fq[1] + 8'(k - 2);
                exp_miso.push_back((k < 2) ? 8'h00 : ref_mem[a]);
            end
            else if (cmd == 8'h03)  exp_miso.push_back(st);
            else                    exp_miso.push_back(8'hFF);
        end
        for (int k = 0; k < ncomplete; k++) begin
            if (k == 0 && !(cmd inside {8'h01, 8'h02, 8'h03}))
                err_model = (err_model < 255) ? err_model + 1 : 255;
            if (cmd == 8'h01 && k >= 2) begin
                a = fq[1] + 8'(k - 2);
                exp_wr.push_back({a, fq[k]});
                ref_mem[a] = fq[k];
            end
            if (cmd == 8'h02 && k >= 1) exp_rd.push_back(fq[1] + 8'(k - 1));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits);
        miso_sample = 1'b1;
        #1 miso_sample = 1'b0;
        spi_busy = 1'b1;
        repeat (nbits) #(2 * HP);
        if (nbits == 8) begin
            spi_in_byte = b;
            #1 spi_busy = 1'b0;
        end
    endtask

    task automatic open_frame();
        spi_cs = 1'b0;
        #(60 + $urandom_range(0, 9));
        check("frame_active_on", frame_active, 1'b1);
    endtask

    task automatic run_frame(input int last_bits);
        int n;
        n = fq.size();
        expect_frame((last_bits == 8) ? n : n - 1, status);
        open_frame();
        for (int k = 0; k < n; k++) begin
            if (k == n - 1 && last_bits != 8) begin
                send_byte(fq[k], last_bits);
                spi_cs = 1'b1;
                #20 spi_busy = 1'b0;
            end else begin
                send_byte(fq[k], 8);
                #(120 + $urandom_range(0, 29));
            end
        end
        spi_cs = 1'b1;
        #(80 + $urandom_range(0, 19));
        check("frame_active_off", frame_active, 1'b0);
        check("err_cnt", err_cnt, err_model[7:0]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out"},      spi_out_byte,  8'h00);
        check({tag, "_we"},       bus.reg_we,    1'b0);
        check({tag, "_re"},       bus.reg_re,    1'b0);
        check({tag, "_addr"},     bus.reg_addr,  8'h00);
        check({tag, "_wdata"},    bus.reg_wdata, 8'h00);
        check({tag, "_err"},      err_cnt,       8'h00);
        check({tag, "_frame"},    frame_active,  1'b0);
    endtask

    initial begin
        logic [7:0] c;
        int len;
        for (int i = 0; i < 256; i++) begin
            rf_mem[i]  = 8'(i * 37 + 11);
            ref_mem[i] = 8'(i * 37 + 11);
        end
        #22 check_all_zero("reset");
        rst = 1'b0;
        #30 check_all_zero("post_reset");

        // write burst
        fq = '{8'h01, 8'h10, 8'hAA, 8'hBB}; run_frame(8);
        // preload then burst read
        fq = '{8'h01, 8'h20, 8'h5A, 8'hC3}; run_frame(8);
        fq = '{8'h02, 8'h20, 8'h11, 8'h22}; run_frame(8);
        // status
        status = 8'h81;
        fq = '{8'h03, 8'h44, 8'h55}; run_frame(8);
        // unknown opcode and saturation of err_cnt
        fq = '{8'h7E, 8'h12, 8'h34}; run_frame(8);
        for (int i = 0; i < 258; i++) begin
            fq = '{8'h7E}; run_frame(8);
        end
        // address wrap and truncated final byte
        fq = '{8'h01, 8'hFF, 8'hD1, 8'hD2, 8'hD3}; run_frame(4);
        status = 8'h3C;
        fq = '{8'h03, 8'h00}; run_frame(8);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            status = 8'($urandom);
            case ($urandom_range(0, 3))
                0: c = 8'h01;
                1: c = 8'h02;
                2: c = 8'h03;
                default: begin
                    c = 8'($urandom);
                    if (c inside {8'h01, 8'h02, 8'h03}) c = c | 8'hC0;
                end
            endcase
            len = $urandom_range(1, 6);
            fq = {};
            fq.push_back(c);
            for (int k = 1; k < len; k++) fq.push_back(8'($urandom));
            run_frame(8);
        end

        // reset in the middle of a read burst
        status = 8'h00;
        fq = '{8'h02, 8'h40, 8'h00, 8'h00};
        expect_frame(3, status);
        open_frame();
        for (int k = 0; k < 3; k++) begin
            send_byte(fq[k], 8);
            #(120 + $urandom_range(0, 29));
        end
        fork
            send_byte(fq[3], 8);
            begin
                #40 rst = 1'b1;
                #1 check_all_zero("mid_reset");
            end
        join
        spi_cs = 1'b1;
        #30 rst = 1'b0;
        err_model = 0;
        exp_miso = {};
        exp_wr = {};
        exp_rd = {};
        #50;
        status = 8'h96;
        fq = '{8'h03, 8'h77}; run_frame(8);

        #200;
        check("miso_left", exp_miso.size(), 0);
        check("writes_left", exp_wr.size(), 0);
        check("reads_left", exp_rd.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
